writeback_buffer: RTL and testbench

WRITEBACK_BUFFER -- requirements
Module: writeback_buffer

---
 rtl/writeback_pkg.sv | 15 +
 rtl/wb_fifo.sv | 89 ++++++++
 rtl/writeback_buffer.sv | 131 +++++++++++++
 tb/tb_writeback_buffer.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/writeback_pkg.sv
// Shared entry type and default sizing for the register-file writeback buffer.
package writeback_pkg;

    localparam int WB_DEPTH  = 4;
    localparam int WB_ADDR_W = 7;
    localparam int WB_DATA_W = 64;
    localparam int WB_MASK_W = WB_DATA_W / 8;

    typedef struct packed {
        logic [WB_ADDR_W-1:0] address;
        logic [WB_DATA_W-1:0] value;
        logic [WB_MASK_W-1:0] byteMask;
    } wb_entry_t;

endpackage

// File: rtl/wb_fifo.sv
// Circular entry store with head/tail pointers, occupancy count and in-place update of the youngest entry.
// Latency: a push is visible at head_dat the cycle after the push edge when the FIFO was empty.
// Backpressure: none internally; the caller must never push when full or pop when empty.
module wb_fifo
    import writeback_pkg::*;
#(
    parameter int DEPTH = WB_DEPTH,
    parameter int W     = $bits(wb_entry_t)
) (
    input  logic                     clock,
    input  logic                     reset_n,
    input  logic                     push,
    input  logic [W-1:0]             push_dat,
    input  logic                     pop,
    input  logic                     merge,
    input  logic [W-1:0]             merge_dat,
    output logic [W-1:0]             head_dat,
    output logic [W-1:0]             tail_dat,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     empty,
    output logic                     full
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [W-1:0]     mem_q [DEPTH];
    logic [PTR_W-1:0] head_q, head_d;
    logic [PTR_W-1:0] tail_q, tail_d;
    logic [PTR_W-1:0] youngest;
    logic [CNT_W-1:0] count_q, count_d;
    logic             wr_en;
    logic [PTR_W-1:0] wr_idx;
    logic [W-1:0]     wr_dat;

    // DEPTH is a power of two, so pointer overflow is the wrap.
    assign youngest = tail_q - PTR_W'(1);

    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        wr_en   = 1'b0;
        wr_idx  = tail_q;
        wr_dat  = push_dat;
        if (push) begin
            wr_en  = 1'b1;
            tail_d = tail_q + PTR_W'(1);
        end else if (merge) begin
            wr_en  = 1'b1;
            wr_idx = youngest;
            wr_dat = merge_dat;
        end
        if (pop) begin
            head_d = head_q + PTR_W'(1);
        end
        case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // Payload storage carries no reset; validity comes from the pointers.
    always_ff @(posedge clock) begin
        if (wr_en) begin
            mem_q[wr_idx] <= wr_dat;
        end
    end

    assign head_dat = mem_q[head_q];
    assign tail_dat = mem_q[youngest];
    assign count    = count_q;
    assign empty    = (count_q == '0);
    assign full     = (count_q == CNT_W'(DEPTH));

endmodule

// File: rtl/writeback_buffer.sv
// Buffers execution results and drains them in order to a granted register-file write port.
// Latency: accept at edge E, earliest pop at E+1, io_write_write high the cycle after the pop edge.
// Backpressure: io_in_ready drops only when all DEPTH slots are occupied. WB_COALESCE_EN merges same-address writes.
module writeback_buffer
    import writeback_pkg::*;
#(
    parameter int DEPTH  = WB_DEPTH,
    parameter int ADDR_W = WB_ADDR_W,
    parameter int DATA_W = WB_DATA_W
) (
    input  logic                       clock,
    input  logic                       reset_n,
    input  logic                       io_in_valid,
    output logic                       io_in_ready,
    input  logic [ADDR_W-1:0]          io_in_address,
    input  logic [DATA_W-1:0]          io_in_value,
    input  logic [DATA_W/8-1:0]        io_in_byteMask,
    input  logic                       io_grant,
    output logic                       io_write_write,
    output logic [ADDR_W-1:0]          io_write_address,
    output logic [DATA_W-1:0]          io_write_value,
    output logic [DATA_W/8-1:0]        io_write_byteMask,
    output logic [$clog2(DEPTH):0]     io_count,
    output logic                       io_empty
);

    localparam int MASK_W  = DATA_W / 8;
    localparam int ENTRY_W = ADDR_W + DATA_W + MASK_W;
    localparam int CNT_W   = $clog2(DEPTH) + 1;
`ifdef WB_COALESCE_EN
    localparam bit COALESCE = 1'b1;
`else
    localparam bit COALESCE = 1'b0;
`endif

    logic               full;
    logic               accept;
    logic               pop;
    logic               do_push;
    logic               do_merge;
    logic [ENTRY_W-1:0] in_dat;
    logic [ENTRY_W-1:0] head_dat;
    logic [ENTRY_W-1:0] tail_dat;
    logic [ENTRY_W-1:0] merge_dat;
    logic [ADDR_W-1:0]  tail_addr;
    logic [DATA_W-1:0]  tail_val;
    logic [MASK_W-1:0]  tail_mask;
    logic [DATA_W-1:0]  bit_en;

    logic               wr_vld_q, wr_vld_d;
    logic [ADDR_W-1:0]  wr_addr_q, wr_addr_d;
    logic [DATA_W-1:0]  wr_val_q, wr_val_d;
    logic [MASK_W-1:0]  wr_mask_q, wr_mask_d;

    // Entries are packed as {address, value, byteMask}, same order as wb_entry_t.
    assign in_dat    = {io_in_address, io_in_value, io_in_byteMask};
    assign tail_addr = tail_dat[ENTRY_W-1 -: ADDR_W];
    assign tail_val  = tail_dat[MASK_W +: DATA_W];
    assign tail_mask = tail_dat[MASK_W-1:0];

    assign io_in_ready = !full;
    assign accept      = io_in_valid && io_in_ready;
    assign pop         = io_grant && !io_empty;

    always_comb begin
        bit_en = '0;
        for (int i = 0; i < MASK_W; i++) begin
            bit_en[8*i +: 8] = {8{io_in_byteMask[i]}};
        end
    end

    assign merge_dat = {tail_addr,
                        (tail_val & ~bit_en) | (io_in_value & bit_en),
                        tail_mask | io_in_byteMask};

    // The youngest entry is only mergeable if it is not leaving at this same edge.
    assign do_merge = COALESCE && accept && (|io_in_byteMask) && !io_empty &&
                      (tail_addr == io_in_address) &&
                      !(pop && (io_count == CNT_W'(1)));
    assign do_push  = accept && (|io_in_byteMask) && !do_merge;

    wb_fifo #(
        .DEPTH (DEPTH),
        .W     (ENTRY_W)
    ) u_fifo (
        .clock     (clock),
        .reset_n   (reset_n),
        .push      (do_push),
        .push_dat  (in_dat),
        .pop       (pop),
        .merge     (do_merge),
        .merge_dat (merge_dat),
        .head_dat  (head_dat),
        .tail_dat  (tail_dat),
        .count     (io_count),
        .empty     (io_empty),
        .full      (full)
    );

    always_comb begin
        wr_vld_d  = pop;
        wr_addr_d = wr_addr_q;
        wr_val_d  = wr_val_q;
        wr_mask_d = wr_mask_q;
        if (pop) begin
            wr_addr_d = head_dat[ENTRY_W-1 -: ADDR_W];
            wr_val_d  = head_dat[MASK_W +: DATA_W];
            wr_mask_d = head_dat[MASK_W-1:0];
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wr_vld_q  <= 1'b0;
            wr_addr_q <= '0;
            wr_val_q  <= '0;
            wr_mask_q <= '0;
        end else begin
            wr_vld_q  <= wr_vld_d;
            wr_addr_q <= wr_addr_d;
            wr_val_q  <= wr_val_d;
            wr_mask_q <= wr_mask_d;
        end
    end

    assign io_write_write    = wr_vld_q;
    assign io_write_address  = wr_addr_q;
    assign io_write_value    = wr_val_q;
    assign io_write_byteMask = wr_mask_q;

endmodule

// File: tb/tb_writeback_buffer.sv
// Scenario bench for writeback_buffer; expectations come from an in-order queue model of accepted writes.
module tb_writeback_buffer;
    import writeback_pkg::*;

    localparam int DEPTH = 4;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        io_in_valid = 1'b0;
    logic        io_in_ready;
    logic [6:0]  io_in_address = '0;
    logic [63:0] io_in_value = '0;
    logic [7:0]  io_in_byteMask = '0;
    logic        io_grant = 1'b0;
    logic        io_write_write;
    logic [6:0]  io_write_address;
    logic [63:0] io_write_value;
    logic [7:0]  io_write_byteMask;
    logic [2:0]  io_count;
    logic        io_empty;

    writeback_buffer #(.DEPTH(DEPTH), .ADDR_W(7), .DATA_W(64)) dut (
        .clock             (clock),
        .reset_n           (reset_n),
        .io_in_valid       (io_in_valid),
        .io_in_ready       (io_in_ready),
        .io_in_address     (io_in_address),
        .io_in_value       (io_in_value),
        .io_in_byteMask    (io_in_byteMask),
        .io_grant          (io_grant),
        .io_write_write    (io_write_write),
        .io_write_address  (io_write_address),
        .io_write_value    (io_write_value),
        .io_write_byteMask (io_write_byteMask),
        .io_count          (io_count),
        .io_empty          (io_empty)
    );

    always #5 clock = ~clock;

    int        checks = 0;
    int        failures = 0;
    wb_entry_t mq[$];
    wb_entry_t got[$];
    logic      exp_wr = 1'b0;
    wb_entry_t exp_out = '0;
    logic      exp_rdy = 1'b1;
    logic      rdy_seen = 1'b1;

    // Drives one cycle of inputs, advances the reference queue, and logs any write the DUT issues.
    task automatic cycle(input logic v, input logic [6:0] a, input logic [63:0] d,
                         input logic [7:0] m, input logic g);
        bit        acc, pp, mrg;
        int        n;
        wb_entry_t e;
        io_in_valid = v; io_in_address = a; io_in_value = d; io_in_byteMask = m; io_grant = g;
        #1;
        rdy_seen = io_in_ready;
        n = mq.size();
        exp_rdy = (n != DEPTH);
        acc = v && exp_rdy;
        pp = g && (n != 0);
        mrg = 1'b0;
`ifdef WB_COALESCE_EN
        if (acc && (m != 8'h00) && (n != 0) && !(pp && n == 1))
            mrg = (mq[$].address == a);
`endif
        @(posedge clock);
        #1;
        exp_wr = pp;
        if (pp) exp_out = mq.pop_front();
        if (mrg) begin
            e = mq[$];
            for (int i = 0; i < 8; i++)
                if (m[i]) e.value[8*i +: 8] = d[8*i +: 8];
            e.byteMask = e.byteMask | m;
            mq[$] = e;
        end else if (acc && (m != 8'h00)) begin
            e.address = a; e.value = d; e.byteMask = m;
            mq.push_back(e);
        end
        if (io_write_write) begin
            e.address = io_write_address; e.value = io_write_value; e.byteMask = io_write_byteMask;
            got.push_back(e);
        end
    endtask

    task automatic test_reset();
        io_in_valid = 1'b1; io_in_address = 7'd5; io_in_value = 64'hFFFF; io_in_byteMask = 8'hFF; io_grant = 1'b1;
        repeat (2) @(posedge clock);
        #1;
        checks++; if (io_write_write !== 1'b0) begin failures++; $display("FAIL reset_write got=%b want=0", io_write_write); end
        checks++; if (io_count !== 3'd0) begin failures++; $display("FAIL reset_count got=%0d want=0", io_count); end
        checks++; if (io_empty !== 1'b1) begin failures++; $display("FAIL reset_empty got=%b want=1", io_empty); end
        checks++; if (io_in_ready !== 1'b1) begin failures++; $display("FAIL reset_ready got=%b want=1", io_in_ready); end
        checks++; if ({io_write_address, io_write_value, io_write_byteMask} !== 79'd0) begin
            failures++; $display("FAIL reset_outregs got=%h want=0", {io_write_address, io_write_value, io_write_byteMask}); end
        io_in_valid = 1'b0; io_grant = 1'b0;
        @(negedge clock);
        reset_n = 1'b1;
    endtask

    task automatic test_single();
        cycle(1'b1, 7'd5, 64'h1122334455667788, 8'hFF, 1'b1);
        checks++; if (io_write_write !== 1'b0) begin failures++; $display("FAIL single_early got=%b want=0", io_write_write); end
        checks++; if (io_count !== 3'd1) begin failures++; $display("FAIL single_count got=%0d want=1", io_count); end
        cycle(1'b0, 7'd0, 64'd0, 8'h00, 1'b1);
        checks++; if (io_write_write !== 1'b1) begin failures++; $display("FAIL single_write got=%b want=1", io_write_write); end
        checks++; if ({io_write_address, io_write_value, io_write_byteMask} !== {7'd5, 64'h1122334455667788, 8'hFF}) begin
            failures++; $display("FAIL single_data got=%h/%h/%h want=05/1122334455667788/ff",
                                 io_write_address, io_write_value, io_write_byteMask); end
        cycle(1'b0, 7'd0, 64'd0, 8'h00, 1'b1);
        checks++; if (io_write_write !== 1'b0) begin failures++; $display("FAIL single_once got=%b want=0", io_write_write); end
        checks++; if (io_write_address !== 7'd5) begin failures++; $display("FAIL single_hold got=%0d want=5", io_write_address); end
    endtask

    task automatic test_fill_wrap();
        logic [7:0] b;
        got.delete();
        for (int i = 0; i < 4; i++) begin
            b = 8'(i + 1);
            cycle(1'b1, 7'(16 + i), {8{b}}, 8'hFF, 1'b0);
            checks++; if (rdy_seen !== 1'b1) begin failures++; $display("FAIL fill_ready%0d got=%b want=1", i, rdy_seen); end
        end
        checks++; if (io_count !== 3'd4) begin failures++; $display("FAIL fill_count got=%0d want=4", io_count); end
        checks++; if (io_in_ready !== 1'b0) begin failures++; $display("FAIL fill_ready_low got=%b want=0", io_in_ready); end
        cycle(1'b1, 7'd20, {8{8'h05}}, 8'hFF, 1'b1);
        checks++; if (io_count !== 3'd3) begin failures++; $display("FAIL full_pop_noacc got=%0d want=3", io_count); end
        cycle(1'b1, 7'd20, {8{8'h05}}, 8'hFF, 1'b1);
        repeat (6) cycle(1'b0, 7'd0, 64'd0, 8'h00, 1'b1);
        checks++; if (got.size() != 5) begin failures++; $display("FAIL wrap_nwrites got=%0d want=5", got.size()); end
        for (int i = 0; i < 5 && i < got.size(); i++) begin
            b = 8'(i + 1);
            checks++;
            if (got[i].address !== 7'(16 + i) || got[i].value !== {8{b}} || got[i].byteMask !== 8'hFF) begin
                failures++; $display("FAIL wrap_order%0d got=%0d/%h want=%0d/%h", i, got[i].address, got[i].value, 16 + i, {8{b}});
            end
        end
    endtask

    task automatic test_zero_mask();
        cycle(1'b1, 7'd9, 64'hDEADBEEF, 8'h00, 1'b0);
        checks++; if (io_count !== 3'd0) begin failures++; $display("FAIL zmask_count got=%0d want=0", io_count); end
        got.delete();
        repeat (3) cycle(1'b0, 7'd0, 64'd0, 8'h00, 1'b1);
        checks++; if (got.size() != 0) begin failures++; $display("FAIL zmask_write got=%0d want=0", got.size()); end
    endtask

    task automatic test_coalesce();
        cycle(1'b1, 7'd3, {8{8'hAA}}, 8'h0F, 1'b0);
        cycle(1'b1, 7'd3, {8{8'hBB}}, 8'hF0, 1'b0);
        got.delete();
`ifdef WB_COALESCE_EN
        checks++; if (io_count !== 3'd1) begin failures++; $display("FAIL coal_count got=%0d want=1", io_count); end
        repeat (4) cycle(1'b0, 7'd0, 64'd0, 8'h00, 1'b1);
        checks++; if (got.size() != 1) begin failures++; $display("FAIL coal_nwrites got=%0d want=1", got.size()); end
        else begin
            checks++;
            if (got[0].byteMask !== 8'hFF || got[0].value !== 64'hBBBBBBBBAAAAAAAA || got[0].address !== 7'd3) begin
                failures++; $display("FAIL coal_data got=%h/%h want=ff/bbbbbbbbaaaaaaaa", got[0].byteMask, got[0].value);
            end
        end
`else
        checks++; if (io_count !== 3'd2) begin failures++; $display("FAIL nocoal_count got=%0d want=2", io_count); end
        repeat (4) cycle(1'b0, 7'd0, 64'd0, 8'h00, 1'b1);
        checks++; if (got.size() != 2) begin failures++; $display("FAIL nocoal_nwrites got=%0d want=2", got.size()); end
        else begin
            checks++;
            if (got[0].byteMask !== 8'h0F || got[0].value !== {8{8'hAA}} ||
                got[1].byteMask !== 8'hF0 || got[1].value !== {8{8'hBB}}) begin
                failures++; $display("FAIL nocoal_data got=%h/%h,%h/%h", got[0].byteMask, got[0].value, got[1].byteMask, got[1].value);
            end
        end
`endif
    endtask

    task automatic test_full_grant_reset();
        int n;
        for (int i = 0; i < 4; i++) cycle(1'b1, 7'(40 + i), {$urandom, $urandom}, 8'hFF, 1'b0);
        checks++; if (io_count !== 3'd4) begin failures++; $display("FAIL fg_fill got=%0d want=4", io_count); end
        for (int i = 0; i < 6; i++) begin
            cycle(1'b1, 7'(50 + i), {$urandom, $urandom}, 8'hFF, 1'b1);
            n = mq.size();
            checks++; if (rdy_seen !== exp_rdy) begin failures++; $display("FAIL fg_ready%0d got=%b want=%b", i, rdy_seen, exp_rdy); end
            checks++; if (io_count !== 3'(n)) begin failures++; $display("FAIL fg_count%0d got=%0d want=%0d", i, io_count, n); end
            checks++; if (io_write_write !== exp_wr) begin failures++; $display("FAIL fg_write%0d got=%b want=%b", i, io_write_write, exp_wr); end
        end
        #2;
        reset_n = 1'b0;
        #1;
        checks++; if (io_write_write !== 1'b0) begin failures++; $display("FAIL async_rst_write got=%b want=0", io_write_write); end
        checks++; if (io_count !== 3'd0) begin failures++; $display("FAIL async_rst_count got=%0d want=0", io_count); end
        checks++; if (io_in_ready !== 1'b1) begin failures++; $display("FAIL async_rst_ready got=%b want=1", io_in_ready); end
        mq.delete();
        exp_wr = 1'b0;
        exp_out = '0;
        @(negedge clock);
        reset_n = 1'b1;
    endtask

    task automatic test_random();
        int        n;
        logic      v, g;
        logic [7:0] m;
        for (int c = 0; c < 400; c++) begin
            v = ($urandom_range(0, 3) != 0);
            g = ($urandom_range(0, 9) < 4);
            m = ($urandom_range(0, 5) == 0) ? 8'h00 : 8'($urandom);
            cycle(v, 7'($urandom_range(0, 3)), {$urandom, $urandom}, m, g);
            n = mq.size();
            checks++; if (rdy_seen !== exp_rdy) begin failures++; $display("FAIL rnd_ready c=%0d got=%b want=%b", c, rdy_seen, exp_rdy); end
            checks++; if (io_write_write !== exp_wr) begin failures++; $display("FAIL rnd_write c=%0d got=%b want=%b", c, io_write_write, exp_wr); end
            checks++; if ({io_write_address, io_write_value, io_write_byteMask} !== exp_out) begin
                failures++; $display("FAIL rnd_data c=%0d got=%h want=%h", c, {io_write_address, io_write_value, io_write_byteMask}, exp_out); end
            checks++; if (io_count !== 3'(n)) begin failures++; $display("FAIL rnd_count c=%0d got=%0d want=%0d", c, io_count, n); end
            checks++; if (io_empty !== (n == 0)) begin failures++; $display("FAIL rnd_empty c=%0d got=%b want=%b", c, io_empty, n == 0); end
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_fill_wrap();
        test_zero_mask();
        test_coalesce();
        test_full_grant_reset();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
